// File: rtl/mtf_pkg.sv
// Shared types and helpers for the MTF spike-processing blocks.
package mtf_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burst_state_t;

  // Increment v, clamping at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    if ({1'b0, v} >= lim) begin
      return lim[31:0];
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/burst_sat_counter.sv
// Saturating up-counter with synchronous load and clear; load wins over clear.
module burst_sat_counter
  import mtf_pkg::*;
#(
  parameter int unsigned W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), W));
    end
  end

endmodule

// File: rtl/spike_burst_decoder.sv
// Groups neuron spike onsets into bursts and emits count/width/period per accepted burst.
module spike_burst_decoder
  import mtf_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned GAP_MAX    = 32,
  parameter int unsigned MIN_SPIKES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike,
  output logic             burst_active,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [7:0]       meas_count,
  output logic [CNT_W-1:0] meas_width,
  output logic [CNT_W-1:0] meas_period,
  output logic             overrun
);

  localparam int unsigned COUNT_W = 8;

  burst_state_t       state_q, state_d;
  logic               spike_q;
  logic               rise_c;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_w_q, last_w_d;
  logic [CNT_W-1:0]   cand_q, cand_d;
  logic               have_prev_q;
  logic [CNT_W-1:0]   w, gap, since_acc;
  logic [CNT_W-1:0]   w_next_c;
  logic               w_clr_c, w_inc_c, gap_clr_c, gap_inc_c;
  logic               close_c, accept_c;

  // spike_q starts high so a spike held across reset release is not an onset.
  always_ff @(posedge clk) begin
    if (reset) spike_q <= 1'b1;
    else       spike_q <= spike;
  end

  assign rise_c   = spike & ~spike_q;
  assign w_next_c = CNT_W'(sat_inc(32'(w), CNT_W));
  assign accept_c = close_c && (cnt_q >= COUNT_W'(MIN_SPIKES));

  burst_sat_counter #(.W(CNT_W)) u_w (
    .clk      (clk),
    .reset    (reset),
    .clr      (w_clr_c),
    .load     (1'b0),
    .load_val ('0),
    .inc      (w_inc_c),
    .q        (w)
  );

  burst_sat_counter #(.W(CNT_W)) u_gap (
    .clk      (clk),
    .reset    (reset),
    .clr      (gap_clr_c),
    .load     (1'b0),
    .load_val ('0),
    .inc      (gap_inc_c),
    .q        (gap)
  );

  burst_sat_counter #(.W(CNT_W)) u_since_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (1'b0),
    .load     (accept_c),
    .load_val (w_next_c),
    .inc      (1'b1),
    .q        (since_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      burst_active <= 1'b0;
      cnt_q        <= '0;
      last_w_q     <= '0;
      cand_q       <= '0;
    end else begin
      state_q      <= state_d;
      burst_active <= (state_d == BURST);
      cnt_q        <= cnt_d;
      last_w_q     <= last_w_d;
      cand_q       <= cand_d;
    end
  end

  // Next state; an onset on the closing cycle keeps the burst open.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_w_d  = last_w_q;
    cand_d    = cand_q;
    w_clr_c   = 1'b0;
    w_inc_c   = 1'b0;
    gap_clr_c = 1'b0;
    gap_inc_c = 1'b0;
    close_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise_c) begin
          state_d   = BURST;
          cnt_d     = COUNT_W'(1);
          last_w_d  = '0;
          w_clr_c   = 1'b1;
          gap_clr_c = 1'b1;
          cand_d    = CNT_W'(sat_inc(32'(since_acc), CNT_W));
        end
      end
      BURST: begin
        w_inc_c = 1'b1;
        if (rise_c) begin
          cnt_d     = COUNT_W'(sat_inc(32'(cnt_q), COUNT_W));
          last_w_d  = w_next_c;
          gap_clr_c = 1'b1;
        end else if (gap == CNT_W'(GAP_MAX - 1)) begin
          close_c = 1'b1;
          state_d = IDLE;
        end else begin
          gap_inc_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Measurement holding register; an accept into a stalled slot is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      have_prev_q <= 1'b0;
      meas_valid  <= 1'b0;
      meas_count  <= '0;
      meas_width  <= '0;
      meas_period <= '0;
      overrun     <= 1'b0;
    end else begin
      if (accept_c) begin
        have_prev_q <= 1'b1;
        if (!meas_valid || meas_ready) begin
          meas_valid  <= 1'b1;
          meas_count  <= cnt_q;
          meas_width  <= last_w_q;
          meas_period <= have_prev_q ? cand_q : '0;
        end else begin
          overrun <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_burst_decoder.sv
// Directed bench for spike_burst_decoder with GAP_MAX=8, MIN_SPIKES=2.
module tb_spike_burst_decoder;

  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             spike;
  logic             burst_active;
  logic             meas_valid;
  logic             meas_ready;
  logic [7:0]       meas_count;
  logic [CNT_W-1:0] meas_width;
  logic [CNT_W-1:0] meas_period;
  logic             overrun;

  int edge_n = 0;
  int passed = 0;
  int total  = 0;

  spike_burst_decoder #(.CNT_W(CNT_W), .GAP_MAX(8), .MIN_SPIKES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .spike        (spike),
    .burst_active (burst_active),
    .meas_valid   (meas_valid),
    .meas_ready   (meas_ready),
    .meas_count   (meas_count),
    .meas_width   (meas_width),
    .meas_period  (meas_period),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) tick();
  endtask

  // One-cycle spike whose onset is sampled at edge k.
  task automatic pulse_at(input int k);
    run_to(k - 1);
    spike = 1'b1;
    tick();
    spike = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    spike = 1'b0;
    repeat (3) tick();
    reset  = 1'b0;
    edge_n = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s at edge %0d: observed=%0d expected=%0d", tag, edge_n, obs, exp);
  endtask

  task automatic chk_meas(input string tag, input int c, input int w, input int p);
    chk({tag, "_valid"},  32'(meas_valid),  32'd1);
    chk({tag, "_count"},  32'(meas_count),  32'(c));
    chk({tag, "_width"},  32'(meas_width),  32'(w));
    chk({tag, "_period"}, 32'(meas_period), 32'(p));
  endtask

  initial begin
    meas_ready = 1'b1;
    do_reset();
    chk("rst_active",  32'(burst_active), 32'd0);
    chk("rst_valid",   32'(meas_valid),   32'd0);
    chk("rst_count",   32'(meas_count),   32'd0);
    chk("rst_width",   32'(meas_width),   32'd0);
    chk("rst_period",  32'(meas_period),  32'd0);
    chk("rst_overrun", 32'(overrun),      32'd0);

    // First accepted burst: onsets 10, 14, 18 -> close at 26.
    run_to(9);
    chk("b1_pre_active", 32'(burst_active), 32'd0);
    pulse_at(10);
    chk("b1_active_10", 32'(burst_active), 32'd1);
    pulse_at(14);
    pulse_at(18);
    run_to(25);
    chk("b1_active_25", 32'(burst_active), 32'd1);
    chk("b1_valid_25",  32'(meas_valid),   32'd0);
    tick();
    chk("b1_active_26", 32'(burst_active), 32'd0);
    chk_meas("b1", 3, 8, 0);
    tick();
    chk("b1_drop_27", 32'(meas_valid), 32'd0);

    // Isolated spike is discarded.
    pulse_at(60);
    chk("iso_active", 32'(burst_active), 32'd1);
    run_to(68);
    chk("iso_closed", 32'(burst_active), 32'd0);
    chk("iso_valid",  32'(meas_valid),   32'd0);
    tick();
    chk("iso_valid2", 32'(meas_valid), 32'd0);

    // Second accepted burst: onsets 110, 113 -> close 121, period 100.
    pulse_at(110);
    pulse_at(113);
    run_to(121);
    chk_meas("b2", 2, 3, 100);
    tick();
    chk("b2_drop", 32'(meas_valid), 32'd0);

    // Backpressure: first result held while a second burst is dropped.
    meas_ready = 1'b0;
    pulse_at(200);
    pulse_at(202);
    run_to(210);
    chk_meas("bp1", 2, 2, 90);
    pulse_at(220);
    pulse_at(222);
    pulse_at(224);
    run_to(231);
    chk("bp_ovr_pre", 32'(overrun), 32'd0);
    tick();
    chk("bp_ovr", 32'(overrun), 32'd1);
    chk_meas("bp_hold", 2, 2, 90);
    meas_ready = 1'b1;
    tick();
    chk("bp_xfer",   32'(meas_valid), 32'd0);
    chk("bp_sticky", 32'(overrun),    32'd1);

    // Ready asserted on the close edge: new data replaces the pending one.
    do_reset();
    meas_ready = 1'b0;
    pulse_at(10);
    pulse_at(12);
    run_to(20);
    chk_meas("rl1", 2, 2, 0);
    pulse_at(30);
    pulse_at(35);
    run_to(42);
    meas_ready = 1'b1;
    tick();
    chk_meas("rl2", 2, 5, 20);
    chk("rl2_ovr", 32'(overrun), 32'd0);
    tick();
    chk("rl2_xfer", 32'(meas_valid), 32'd0);

    // Onset exactly on the would-be close edge extends the burst.
    pulse_at(60);
    pulse_at(64);
    pulse_at(72);
    chk("ext_active", 32'(burst_active), 32'd1);
    chk("ext_valid",  32'(meas_valid),   32'd0);
    run_to(79);
    chk("ext_active79", 32'(burst_active), 32'd1);
    tick();
    chk("ext_closed", 32'(burst_active), 32'd0);
    chk_meas("ext", 3, 12, 30);
    tick();

    // Spike held for 20 cycles counts one onset and is discarded.
    run_to(99);
    spike = 1'b1;
    repeat (20) tick();
    spike = 1'b0;
    chk("held_active", 32'(burst_active), 32'd0);
    chk("held_valid",  32'(meas_valid),   32'd0);
    run_to(125);
    chk("held_valid2", 32'(meas_valid), 32'd0);

    // Reset mid-burst with spike held high across release.
    pulse_at(140);
    pulse_at(142);
    chk("mid_active", 32'(burst_active), 32'd1);
    reset = 1'b1;
    spike = 1'b1;
    repeat (2) tick();
    chk("mr_active",  32'(burst_active), 32'd0);
    chk("mr_valid",   32'(meas_valid),   32'd0);
    chk("mr_overrun", 32'(overrun),      32'd0);
    reset  = 1'b0;
    edge_n = 0;
    run_to(5);
    chk("hold_active", 32'(burst_active), 32'd0);
    spike = 1'b0;
    run_to(15);
    chk("hold_valid",  32'(meas_valid),  32'd0);
    chk("hold_count",  32'(meas_count),  32'd0);
    chk("hold_active2", 32'(burst_active), 32'd0);

    // First burst after reset reports period 0 again.
    pulse_at(20);
    pulse_at(23);
    run_to(31);
    chk_meas("post", 2, 3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spike_burst_decoder.md
# spike_burst_decoder

Downstream consumer of the MTF neuron's `spike` output. It groups spikes into bursts, measures each accepted burst, and presents the result to the gait/servo mapper over a valid/ready handshake. Measured values are spike count, burst width (first-to-last spike onset) and onset-to-onset period. The measured period and duty are what the CPG layer reads as oscillation rhythm.

## Interface
Parameters:
- `CNT_W`, 16: width of the width and period counters; all counters saturate at 2^CNT_W-1.
- `GAP_MAX`, 32: quiet cycles after the last spike onset that close a burst; legal range 2..2^CNT_W-1.
- `MIN_SPIKES`, 2: minimum spike onsets for a burst to be accepted; legal range 1..255.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `spike` in 1: neuron spike level; may stay high for multiple cycles.
- `burst_active` out 1: high while the FSM is in BURST.
- `meas_valid` out 1: measurement available.
- `meas_ready` in 1: consumer accepts the measurement.
- `meas_count` out 8: spike onsets in the burst, saturating at 255.
- `meas_width` out CNT_W: cycles from first to last onset.
- `meas_period` out CNT_W: cycles between this accepted onset and the previous accepted onset; 0 for the first burst after reset.
- `overrun` out 1: sticky; set when an accepted burst is dropped.

## Operation
- Onset detection: `rise = spike & ~spike_q`, with `spike_q` registered. `spike_q` resets to 1, so a spike held high across reset release produces no onset.
- FSM has two states, IDLE and BURST; reset state is IDLE.
- IDLE, on `rise`:
  - go to BURST;
  - `cnt` ← 1, `w` ← 0, `last_w` ← 0, `gap` ← 0;
  - `cand` ← sat(`since_acc`+1).
- BURST, every cycle:
  - `w` ← sat(`w`+1).
  - On `rise`: `cnt` ← sat(`cnt`+1), `last_w` ← sat(`w`+1), `gap` ← 0.
  - Otherwise, if `gap` == GAP_MAX-1: close the burst and return to IDLE.
  - Otherwise: `gap` ← `gap`+1.
  - `rise` takes priority over closing in the same cycle.
- Close:
  - If `cnt` < MIN_SPIKES, discard the burst. Nothing is emitted and `since_acc` is untouched.
  - Otherwise accept it:
    - `since_acc` ← sat(`w`+1);
    - `have_prev` ← 1;
    - `meas_count` ← `cnt`, `meas_width` ← `last_w`;
    - `meas_period` ← `have_prev` ? `cand` : 0, using the old value of `have_prev`.
- `since_acc` increments, saturating, every cycle except on accept.
- Handshake:
  - `meas_*` data is stable while `meas_valid` && !`meas_ready`.
  - Transfer happens on `meas_valid` && `meas_ready`.
  - If an accept coincides with a transfer, the new data loads and `meas_valid` stays 1.
  - If an accept occurs while `meas_valid` && !`meas_ready`, the new measurement is dropped and `overrun` ← 1.
- Reset values: all outputs 0, `cnt`/`w`/`gap`/`since_acc`/`have_prev` 0, state IDLE. Reset mid-burst discards the burst with no output.

## Timing
- An onset sampled at edge k puts `burst_active` high after edge k (one clock latency from `spike` going high).
- Last onset at edge L with no later onset: close at edge L+GAP_MAX. `burst_active` falls and `meas_valid` rises after that same edge.
- `meas_width` = L−k. `meas_period` = onset-edge difference between consecutive accepted bursts.
- A new onset at the closing edge or later starts a new burst no earlier than the edge after close, since IDLE is required first.
- A spike onset during the close edge extends the current burst.
- `meas_valid` falls one edge after transfer unless reloaded.
- No combinational path from `meas_ready` to `meas_valid`/data.

## Structure
- Shared package `mtf_pkg`:
  - state enum `burst_state_t` (IDLE, BURST);
  - default `CNT_W`;
  - the `sat_inc` function.
- One sub-module: `burst_sat_counter`, a parameterised saturating counter with clear/load. It is instantiated for `w`, `gap` and `since_acc`.
- The handshake output register stays in the top level.

## Test plan
All scenarios use GAP_MAX=8 and MIN_SPIKES=2, with `meas_ready`=1 unless stated.
- First accepted burst: after reset, 1-cycle spikes at edges 10, 14, 18 → `burst_active` high edges 10..26, `meas_valid` after edge 26 with count=3, width=8, period=0.
- Second accepted burst: next burst with onsets at edges 110 and 113 → count=2, width=3, period=100.
- Isolated spike: a single spike at edge 60 between the two bursts → no `meas_valid`; second burst period still 100.
- Backpressure: `meas_ready`=0 with first result pending while another burst closes → `overrun`=1 and held data unchanged. With `meas_ready` asserted on the close edge instead → new data loads, `overrun`=0.
- Onset on the close edge: onset exactly at edge L+8 → burst extends, one measurement, width includes it. Also a spike held high for 20 cycles → count=1, discarded.
- Reset cases: reset asserted mid-burst, plus `spike` held high across reset release → all outputs 0, no onset, no measurement.
